// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver: segment encoding and the hex-to-segment table.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef logic [7:0] an_t;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_c
);

    assign seg_c = hex2seg(nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: per-frame shadow of the display word, guarded digit scan,
// registered active-low anode and segment outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIG       = 8,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [4*N_DIG-1:0] din,
    input  logic [N_DIG-1:0]   dp_in,
    input  logic [N_DIG-1:0]   blank_in,
    output logic [N_DIG-1:0]   an,
    output logic [7:0]         sseg,
    output logic               frame_tk
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = $clog2(N_DIG);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [4*N_DIG-1:0] sh_din_q, sh_din_d;
    logic [N_DIG-1:0]   sh_dp_q, sh_dp_d;
    logic [N_DIG-1:0]   sh_blank_q, sh_blank_d;
    logic               load_pend_q, load_pend_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic [7:0]         sseg_q, sseg_d;
    logic               frame_tk_q, frame_tk_d;

    logic               last_cnt_c;
    logic               frame_end_c;
    logic               guard_ok_c;
    logic [3:0]         nib_c;
    logic [6:0]         seg_c;

    assign nib_c       = sh_din_q[{idx_q, 2'b00} +: 4];
    assign last_cnt_c  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign frame_end_c = last_cnt_c && (idx_q == IDX_W'(N_DIG - 1));

    // Anode may only be enabled once the slot has passed its dark guard window
    if (GUARD == 0) begin : g_noguard
        assign guard_ok_c = 1'b1;
    end else begin : g_guard
        assign guard_ok_c = (cnt_q >= CNT_W'(GUARD));
    end

    seg7_hex_decode u_dec (
        .nib   (nib_c),
        .seg_c (seg_c)
    );

    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sh_din_d    = sh_din_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        load_pend_d = load_pend_q;
        an_d        = '1;
        sseg_d      = SEG_OFF;
        frame_tk_d  = 1'b0;

        if (en) begin
            cnt_d = last_cnt_c ? '0 : cnt_q + CNT_W'(1);
            if (last_cnt_c) begin
                idx_d = (idx_q == IDX_W'(N_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
            end
            // Shadow refresh only at frame edges so a mid-frame write never tears
            if (load_pend_q || frame_end_c) begin
                sh_din_d    = din;
                sh_dp_d     = dp_in;
                sh_blank_d  = blank_in;
                load_pend_d = 1'b0;
            end
            frame_tk_d = frame_end_c;
            if (guard_ok_c) begin
                an_d = ~(N_DIG'(1) << idx_q);
            end
            sseg_d = sh_blank_q[idx_q] ? SEG_OFF : {~sh_dp_q[idx_q], seg_c};
        end else begin
            cnt_d       = '0;
            idx_d       = '0;
            load_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_din_q    <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '0;
            load_pend_q <= 1'b1;
            an_q        <= '1;
            sseg_q      <= SEG_OFF;
            frame_tk_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_din_q    <= sh_din_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            load_pend_q <= load_pend_d;
            an_q        <= an_d;
            sseg_q      <= sseg_d;
            frame_tk_q  <= frame_tk_d;
        end
    end

    assign an       = an_q;
    assign sseg     = sseg_q;
    assign frame_tk = frame_tk_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIG=4, REFRESH_DIV=8, GUARD=2.
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame_tk;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(
        .N_DIG       (4),
        .REFRESH_DIV (8),
        .GUARD       (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .din      (din),
        .dp_in    (dp_in),
        .blank_in (blank_in),
        .an       (an),
        .sseg     (sseg),
        .frame_tk (frame_tk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // At most one anode may be driven at any time
    always @(negedge clk) begin
        if (!reset) begin
            chk("onehot_an", 8'($countones(~an) <= 1), 8'd1);
        end
    end

    initial begin
        logic [7:0] f1_seg [4];
        logic [3:0] exp_an;
        int         p;
        int         cnt;
        int         idx;

        f1_seg[0] = 8'h99;
        f1_seg[1] = 8'hB0;
        f1_seg[2] = 8'hA4;
        f1_seg[3] = 8'hF9;

        reset    = 1'b1;
        en       = 1'b1;
        din      = 16'h1234;
        dp_in    = 4'b0000;
        blank_in = 4'b0000;

        #12;
        chk("reset_an", 8'(an), 8'h0F);
        chk("reset_sseg", sseg, 8'hFF);
        chk("reset_frame_tk", 8'(frame_tk), 8'h00);

        @(posedge clk);
        #1;
        reset = 1'b0;

        // Frame 1: 1234 displayed; mid-frame write must not show up
        for (int k = 1; k <= 32; k++) begin
            step();
            p      = k - 1;
            cnt    = p % 8;
            idx    = p / 8;
            exp_an = 4'hF;
            if (cnt >= 2) exp_an[idx] = 1'b0;
            chk($sformatf("f1_an_k%0d", k), 8'(an), 8'(exp_an));
            chk($sformatf("f1_sseg_k%0d", k), sseg, (k == 1) ? 8'hC0 : f1_seg[idx]);
            chk($sformatf("f1_tk_k%0d", k), 8'(frame_tk), (k == 32) ? 8'h01 : 8'h00);
            if (k == 12) din = 16'hABCD;
        end

        // Frames 2 and 3: new word, then dp/blank take effect only at the next frame
        for (int k = 33; k <= 96; k++) begin
            step();
            chk($sformatf("tk_k%0d", k), 8'(frame_tk), (k == 64 || k == 96) ? 8'h01 : 8'h00);
            if (k == 33) begin
                chk("f2_d0_guard_an", 8'(an), 8'h0F);
                chk("f2_d0_sseg_early", sseg, 8'hA1);
            end
            if (k == 35) begin
                chk("f2_d0_an", 8'(an), 8'h0E);
                chk("f2_d0_sseg", sseg, 8'hA1);
            end
            if (k == 40) begin
                dp_in    = 4'b0010;
                blank_in = 4'b1000;
            end
            if (k == 43) begin
                chk("f2_d1_an", 8'(an), 8'h0D);
                chk("f2_d1_sseg_nodp", sseg, 8'hC6);
            end
            if (k == 67) begin
                chk("f3_d0_an", 8'(an), 8'h0E);
                chk("f3_d0_sseg", sseg, 8'hA1);
            end
            if (k == 75) begin
                chk("f3_d1_an", 8'(an), 8'h0D);
                chk("f3_d1_sseg_dp", sseg, 8'h46);
            end
            if (k == 83) begin
                chk("f3_d2_an", 8'(an), 8'h0B);
                chk("f3_d2_sseg", sseg, 8'h83);
            end
            if (k == 91) begin
                chk("f3_d3_an", 8'(an), 8'h07);
                chk("f3_d3_sseg_blank", sseg, 8'hFF);
            end
        end

        repeat (4) step();

        // Enable dropped mid-slot for five cycles
        en       = 1'b0;
        din      = 16'h5678;
        dp_in    = 4'b0000;
        blank_in = 4'b0000;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("en0_an_%0d", i), 8'(an), 8'h0F);
            chk($sformatf("en0_sseg_%0d", i), sseg, 8'hFF);
            chk($sformatf("en0_tk_%0d", i), 8'(frame_tk), 8'h00);
        end
        en = 1'b1;

        step();
        chk("reen_k1_an", 8'(an), 8'h0F);
        step();
        chk("reen_k2_an", 8'(an), 8'h0F);
        chk("reen_k2_sseg", sseg, 8'h80);
        step();
        chk("reen_k3_an", 8'(an), 8'h0E);
        chk("reen_k3_sseg", sseg, 8'h80);
        repeat (13) step();
        chk("reen_k16_an", 8'(an), 8'h0D);
        chk("reen_k16_sseg", sseg, 8'hF8);

        // Async reset at the start of the digit-2 guard window
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_an", 8'(an), 8'h0F);
        chk("async_rst_sseg", sseg, 8'hFF);
        chk("async_rst_tk", 8'(frame_tk), 8'h00);
        @(posedge clk);
        #1;
        chk("rst_hold_an", 8'(an), 8'h0F);
        reset = 1'b0;

        step();
        chk("post_rst_k1_an", 8'(an), 8'h0F);
        chk("post_rst_k1_sseg", sseg, 8'hC0);
        step();
        step();
        chk("post_rst_k3_an", 8'(an), 8'h0E);
        chk("post_rst_k3_sseg", sseg, 8'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
